div_iter: RTL and testbench

Parametrised multi-cycle integer divider for the stpu execute stage. It is the successor of the fixed 32-bit divider: operand width is configurable, and it adds an explicit busy flag, a divide-by-zero flag and a one-cycle early-out for trivial operands. It sits beside the EX stage. EX drives operands and start, and holds the pipeline stalled until `ready_o`. The result layout {remainder, quotient} is unchanged so EX/HILO wiring carries over.

---
 rtl/div_iter.sv | 148 ++++++++++++++
 tb/tb_div_iter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: parametrised multi-cycle restoring integer divider for the EX stage.
//
// Handshake: EX raises start_i with operands and keeps it high until it has
// consumed the result. The divider samples the operands on the first edge
// where it is IDLE with start_i=1 and annul_i=0. It raises ready_o while the
// result is valid, and holds that result until start_i drops. annul_i aborts
// any operation in flight.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   signed_div_i  1 = two's-complement divide, 0 = unsigned (sampled with start)
//   opdata1_i     dividend (sampled with start)
//   opdata2_i     divisor  (sampled with start)
//   start_i       request, level-held by EX
//   annul_i       abort the current or pending operation
//   result_o      {remainder, quotient}, valid while ready_o
//   ready_o       result valid (state DONE)
//   busy_o        iterating (state BUSY)
//   divzero_o     the completed operation had divisor = 0
//   dbg_state     current FSM state, for debug and checkers
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               divzero_o,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH:0]   rem;      // partial remainder
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             trivial;
  logic             last;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    // Magnitude conversion; the most negative value maps onto 2^(W-1),
    // which is representable as an unsigned WIDTH-bit number.
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    accept  = (state == IDLE) && start_i && !annul_i;
    trivial = (opdata2_i == '0) || (opdata1_i == '0);
    last    = (cnt == CW'(WIDTH - 1));

    // One restoring step. The subtraction is one bit wider than the shifted
    // remainder so its top bit is a reliable borrow.
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {2'b00, dvs};
    q_bit   = ~diff[WIDTH+1];
    rem_nxt = q_bit ? diff[WIDTH:0] : rem_sh[WIDTH:0];
    quo_nxt = {quo[WIDTH-2:0], q_bit};

    quo_fix = neg_q ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
    rem_fix = neg_r ? (~rem_nxt[WIDTH-1:0] + WIDTH'(1)) : rem_nxt[WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = trivial ? DONE : BUSY;
      BUSY: begin
        if (annul_i)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: if (annul_i || !start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      quo       <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_o  <= '0;
      divzero_o <= 1'b0;
    end else if (annul_i && (state != IDLE)) begin
      // Annul wins over iteration and completion on the same edge.
      cnt       <= '0;
      result_o  <= '0;
      divzero_o <= 1'b0;
    end else if (accept) begin
      quo       <= mag1;
      dvs       <= mag2;
      rem       <= '0;
      cnt       <= '0;
      neg_q     <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_r     <= signed_div_i & opdata1_i[WIDTH-1];
      result_o  <= '0;
      divzero_o <= (opdata2_i == '0);
    end else if (state == BUSY) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + CW'(1);
      // Sign correction is registered together with the move to DONE.
      if (last) result_o <= {rem_fix, quo_fix};
    end
  end

  assign busy_o    = (state == BUSY);
  assign ready_o   = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (WIDTH=32 main instance,
// WIDTH=8 secondary instance).
module tb_div_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=32 instance ----------------
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;
  logic           divzero_o;
  logic [1:0]     dbg_state;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o),
    .divzero_o(divzero_o), .dbg_state(dbg_state)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic        s8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        start8;
  logic        annul8;
  logic [15:0] res8;
  logic        ready8;
  logic        busy8;
  logic        dz8;
  logic [1:0]  dbg8;

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(s8),
    .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8),
    .result_o(res8), .ready_o(ready8), .busy_o(busy8),
    .divzero_o(dz8), .dbg_state(dbg8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W:0] exp_q[$];   // {divzero, remainder, quotient}
  logic [2*W:0] mon_exp;
  logic         ready_prev;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division with the
  // remainder taking the dividend's sign.
  function automatic logic [2*W:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {1'b1, {(2*W){1'b0}}};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // Monitor: every rising edge of ready_o consumes one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      ready_prev = 1'b0;
    end else begin
      if (ready_o && !ready_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", {divzero_o, result_o}, mon_exp);
        end
      end
      ready_prev = ready_o;
    end
  end

  // ---------------- drivers ----------------
  // drop_at > 0 drops start_i during BUSY; otherwise start_i is held for
  // 'hold' extra cycles in DONE before it falls.
  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W:0] exp, input int drop_at, input int hold);
    logic trivial;
    int n, nbusy;
    trivial      = (a == '0) || (b == '0);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    // Operand changes after acceptance must not matter.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    n = 1;
    nbusy = 0;
    while (!ready_o && n < 100) begin
      if (busy_o) nbusy++;
      if (n == drop_at) start_i = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, trivial ? 1 : W + 1);
    check("busy_cycles", nbusy, trivial ? 0 : W);
    if (drop_at > 0) begin
      @(posedge clk); #1;
      check("ready_one_cycle", ready_o, 0);
    end else begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("ready_held", {ready_o, divzero_o, result_o}, {1'b1, exp});
      end
      start_i = 1'b0;
      @(posedge clk); #1;
      check("ready_falls", ready_o, 0);
    end
  endtask

  task automatic do_op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    s8 = sgn;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!ready8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", n, 9);
    check("w8_result", {dz8, res8}, {1'b0, exp});
    start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0; start_i = 1'b0; annul_i = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0; start8 = 1'b0; annul8 = 1'b0;
    #12;
    check("reset_outputs", {result_o, ready_o, busy_o, divzero_o, dbg_state}, '0);
    check("reset_outputs_w8", {res8, ready8, busy8, dz8, dbg8}, '0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases; the first is accepted on the first edge after reset.
    do_op(1'b0, 32'd100, 32'd7, {1'b0, 64'h00000002_0000000E}, 0, 1);
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, {1'b0, 64'hFFFFFFFF_FFFFFFFD}, 0, 0);
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, {1'b0, 64'h00000001_FFFFFFFD}, 0, 2);
    do_op(1'b0, 32'd5, 32'd0, {1'b1, 64'h0}, 0, 2);
    do_op(1'b0, 32'd0, 32'd9, {1'b0, 64'h0}, 0, 0);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {1'b0, 64'h00000000_80000000}, 0, 0);
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, {1'b0, 64'h00000000_FFFFFFFF}, 12, 0);

    // Annul on the 10th BUSY cycle; no result may appear.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    check("busy_before_annul", busy_o, 1);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_clears", {result_o, ready_o, busy_o, divzero_o, dbg_state}, '0);
    @(posedge clk); #1;
    check("annul_blocks_accept", {busy_o, ready_o}, 2'b00);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    do_op(1'b0, 32'd100, 32'd7, {1'b0, 64'h00000002_0000000E}, 0, 0);

    // Asynchronous reset in the middle of BUSY.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {result_o, ready_o, busy_o, divzero_o, dbg_state}, '0);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b0, 32'd100, 32'd7, {1'b0, 64'h00000002_0000000E}, 0, 0);

    // WIDTH=8 runs
    do_op8(1'b0, 8'd200, 8'd3, 16'h0242);
    do_op8(1'b1, 8'h80, 8'hFF, 16'h0080);
    do_op8(1'b1, 8'hF9, 8'h02, 16'hFFFD);
    do_op8(1'b1, 8'h07, 8'hFE, 16'h01FD);
    do_op8(1'b0, 8'hFF, 8'h10, 16'h0F0F);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        sgn;
      logic [W-1:0] a, b;
      int kind, drop;
      sgn  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (kind)
        0: b = '0;
        1: a = '0;
        2: b = W'($urandom_range(1, 15));
        3: a = 32'h80000000;
        4: b = 32'hFFFFFFFF;
        default: ;
      endcase
      drop = (kind == 7 && a != '0 && b != '0) ? $urandom_range(2, 20) : 0;
      do_op(sgn, a, b, ref_div(sgn, a, b), drop, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
